// File: rtl/sphere_contact_buffer_if.sv
// Outbound contact word stream: one 32-bit word per valid/ready beat, with
// out_last marking the ninth (final) word of each contact record.
`timescale 1ns/1ps
interface sphere_contact_buffer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/sphere_contact_buffer.sv
// Contact-result FIFO between the sphere-sphere collision core and the CPU bridge.
// Optional macro CONTACT_STATS_EN adds hit_cnt/miss_cnt capture counters.
`timescale 1ns/1ps
module sphere_contact_buffer #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic          ret,
  input  logic [31:0]   cx,
  input  logic [31:0]   cy,
  input  logic [31:0]   cz,
  input  logic [31:0]   normalx,
  input  logic [31:0]   normaly,
  input  logic [31:0]   normalz,
  input  logic [31:0]   depth,
  input  logic [31:0]   g1,
  input  logic [31:0]   g2,
  sphere_contact_buffer_if.master out_if,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow
`ifdef CONTACT_STATS_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = 9;

  typedef enum logic {IDLE, STREAM} state_t;

  logic          d1_q, d2_q, d3_q;
  logic          cap, push, pop, drop, full_w, empty_w;
  logic [31:0]   in_words [NW];
  logic [31:0]   mem_q [DEPTH][NW];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d, idx_nxt;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   out_data_q, out_data_d;

  assign in_words[0] = cx;
  assign in_words[1] = cy;
  assign in_words[2] = cz;
  assign in_words[3] = normalx;
  assign in_words[4] = normaly;
  assign in_words[5] = normalz;
  assign in_words[6] = depth;
  assign in_words[7] = g1;
  assign in_words[8] = g2;

  assign cap     = d2_q & ~d3_q;
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign pop     = (state_q == STREAM) & out_valid_q & out_if.out_ready & (idx_q == 4'd8);
  // A final-word pop frees its slot this cycle, so a capture while full still fits.
  assign push    = cap & ret & (~full_w | pop);
  assign drop    = cap & ret & full_w & ~pop;
  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign idx_nxt = idx_q + 4'd1;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    overflow_d = overflow_q | drop;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        idx_d       = 4'd0;
        if (!empty_w) state_d = STREAM;
      end
      STREAM: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_ptr_q][idx_q];
          out_last_d  = (idx_q == 4'd8);
        end else if (out_if.out_ready) begin
          if (idx_q != 4'd8) begin
            idx_d      = idx_nxt;
            out_data_d = mem_q[rd_ptr_q][idx_nxt];
            out_last_d = (idx_q == 4'd7);
          end else begin
            rd_ptr_d   = rd_nxt;
            idx_d      = 4'd0;
            out_last_d = 1'b0;
            // Chain straight into the next entry only if it was written before
            // this cycle; an entry arriving now is picked up one cycle later.
            if (count_q > CW'(1)) begin
              out_data_d = mem_q[rd_nxt][0];
            end else begin
              out_valid_d = 1'b0;
              if (!push) state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      d3_q        <= 1'b0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      d1_q        <= done;
      d2_q        <= d1_q;
      d3_q        <= d2_q;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int w = 0; w < NW; w++) mem_q[wr_ptr_q][w] <= in_words[w];
    end
  end

`ifdef CONTACT_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, cap & ret};
    miss_cnt_d = miss_cnt_q + {31'd0, cap & ~ret};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign count             = count_q;
  assign empty             = empty_w;
  assign full              = full_w;
  assign overflow          = overflow_q;
  assign out_if.out_data   = out_data_q;
  assign out_if.out_valid  = out_valid_q;
  assign out_if.out_last   = out_last_q;

endmodule
